// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage holding the PC and the IF/ID pipeline register
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_en,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_target,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_instr,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_pc_next,
   output logic        if_id_valid,
   output logic [15:0] fetch_count
);
   logic [15:0] pc;

   assign imem_addr = pc;

   // PC and IF/ID update with priority redirect > stall > fetch disabled > normal fetch
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pc            <= RESET_PC;
         if_id_instr   <= 16'h0000;
         if_id_pc      <= 16'h0000;
         if_id_pc_next <= 16'h0000;
         if_id_valid   <= 1'b0;
         fetch_count   <= 16'h0000;
      end else if (redirect) begin
         pc          <= redirect_target;
         if_id_instr <= 16'h0000;
         if_id_valid <= 1'b0;
      end else if (stall) begin
         pc <= pc;
      end else if (!fetch_en) begin
         if_id_instr <= 16'h0000;
         if_id_valid <= 1'b0;
      end else begin
         pc            <= pc + PC_STEP;
         if_id_instr   <= imem_instr;
         if_id_pc      <= pc;
         if_id_pc_next <= pc + PC_STEP;
         if_id_valid   <= 1'b1;
         fetch_count   <= (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, corner sequences and a random run against a reference model
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic [15:0] imem_addr;
   logic [15:0] imem_instr;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_pc_next;
   logic        if_id_valid;
   logic [15:0] fetch_count;

   logic [15:0] mem [256];
   int checks = 0;
   int errors = 0;

   logic [15:0] m_pc, m_i, m_ipc, m_ipcn, m_cnt;
   logic        m_v;

   typedef struct {
      logic        en, st, rd;
      logic [15:0] tgt, e_instr, e_ipc, e_ipcn;
      logic        e_valid;
      logic [15:0] e_pc, e_cnt;
   } vec_t;
   vec_t vecs[$];

   fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .stall(stall),
      .redirect(redirect), .redirect_target(redirect_target), .imem_addr(imem_addr),
      .imem_instr(imem_instr), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
   );

   assign imem_instr = mem[imem_addr[7:0]];

   always #5 clk = ~clk;

   function automatic vec_t mk(logic en, logic st, logic rd, logic [15:0] tgt,
                               logic [15:0] ei, logic [15:0] ep, logic [15:0] epn,
                               logic ev, logic [15:0] epc, logic [15:0] ec);
      vec_t v;
      v.en = en; v.st = st; v.rd = rd; v.tgt = tgt;
      v.e_instr = ei; v.e_ipc = ep; v.e_ipcn = epn; v.e_valid = ev;
      v.e_pc = epc; v.e_cnt = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                            input logic [15:0] epn, input logic ev, input logic [15:0] epc,
                            input logic [15:0] ec);
      check({tag, " instr"}, if_id_instr, ei);
      check({tag, " if_pc"}, if_id_pc, ep);
      check({tag, " if_pc_next"}, if_id_pc_next, epn);
      check({tag, " valid"}, {15'd0, if_id_valid}, {15'd0, ev});
      check({tag, " imem_addr"}, imem_addr, epc);
      check({tag, " count"}, fetch_count, ec);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0000;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      m_pc = 16'h0000; m_i = 16'h0000; m_ipc = 16'h0000; m_ipcn = 16'h0000; m_v = 1'b0; m_cnt = 16'h0000;
   endtask

   // reference: one clock edge of the fetch stage, applying the priority rules directly
   task automatic model_step(input logic en, input logic st, input logic rd, input logic [15:0] tgt);
      if (rd) begin
         m_pc = tgt; m_v = 1'b0; m_i = 16'h0000;
      end else if (!st && !en) begin
         m_v = 1'b0; m_i = 16'h0000;
      end else if (!st) begin
         m_i = mem[m_pc[7:0]]; m_ipc = m_pc; m_ipcn = m_pc + 16'd1; m_v = 1'b1;
         m_pc = m_pc + 16'd1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
   endtask

   task automatic apply(input logic en, input logic st, input logic rd, input logic [15:0] tgt);
      fetch_en = en; stall = st; redirect = rd; redirect_target = tgt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h2009; mem[1] = 16'h200A; mem[2] = 16'h012A; mem[3] = 16'h012B;
      mem[255] = 16'h1234;

      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h2009, 16'h0000, 16'h0001, 1, 16'h0001, 16'd1));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 16'h0002, 16'd2));
      vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 16'h0002, 16'd2));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 16'h0002, 16'd2));
      vecs.push_back(mk(1, 1, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 16'h0002, 16'd2));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 16'h0003, 16'd3));
      vecs.push_back(mk(1, 1, 1, 16'h0001, 16'h0000, 16'h0002, 16'h0003, 0, 16'h0001, 16'd3));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 16'h0002, 16'd4));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 0, 16'h0002, 16'd4));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 0, 16'h0002, 16'd4));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 16'h0003, 16'd5));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h012B, 16'h0003, 16'h0004, 1, 16'h0004, 16'd6));
      vecs.push_back(mk(0, 0, 1, 16'hFFFF, 16'h0000, 16'h0003, 16'h0004, 0, 16'hFFFF, 16'd6));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'd7));
      vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h2009, 16'h0000, 16'h0001, 1, 16'h0001, 16'd8));

      do_reset();
      check_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
      foreach (vecs[k]) begin
         apply(vecs[k].en, vecs[k].st, vecs[k].rd, vecs[k].tgt);
         check_all($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_ipc, vecs[k].e_ipcn,
                   vecs[k].e_valid, vecs[k].e_pc, vecs[k].e_cnt);
      end

      // asynchronous reset between edges while stalled
      apply(1, 1, 0, 16'h0000);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      stall = 1'b0;
      apply(1, 0, 0, 16'h0000);
      check_all("post_rst", 16'h2009, 16'h0000, 16'h0001, 1, 16'h0001, 16'd1);

      // randomized run against the reference model
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic en, st, rd;
         logic [15:0] tgt;
         en = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 4) == 0);
         rd = ($urandom_range(0, 7) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
         model_step(en, st, rd, tgt);
         apply(en, st, rd, tgt);
         check_all("rand", m_i, m_ipc, m_ipcn, m_v, m_pc, m_cnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the simplified 16-bit MIPS pipeline. Holds the program counter and drives the word address into the combinational InstructionMemory. Captures the returned instruction into the IF/ID pipeline register. Handles decode-stage stalls, branch/jump redirects from downstream, and a global fetch enable.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetch (memory is word-addressed, one 16-bit instruction per address)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetch proceeds; 0 = PC holds, bubble into IF/ID
stall  input  1  1 = hold PC and IF/ID contents (decode cannot accept)
redirect  input  1  1 = branch/jump taken; load PC from redirect_target, squash fetch
redirect_target  input  16  new PC on redirect
imem_addr  output  16  address to InstructionMemory, equals pc (combinational)
imem_instr  input  16  instruction returned combinationally by InstructionMemory
if_id_instr  output  16  registered instruction to decode
if_id_pc  output  16  registered PC of if_id_instr
if_id_pc_next  output  16  registered if_id_pc + PC_STEP (link/branch base)
if_id_valid  output  1  if_id_instr is a real instruction
fetch_count  output  16  number of instructions latched valid since reset

Behaviour:
- Reset (reset_n=0, asynchronous, effective immediately):
  - pc=RESET_PC
  - if_id_instr=16'h0000 (NOP), if_id_pc=0, if_id_pc_next=0, if_id_valid=0
  - fetch_count=0
- imem_addr = pc at all times, no register. The full 16 bits are driven; memory uses the low bits it implements.
- Latency: the instruction at pc appears on if_id_instr one rising edge later.
- Per-edge priority is redirect > stall > !fetch_en > normal.
- Normal (fetch_en=1, stall=0, redirect=0):
  - if_id_instr<=imem_instr, if_id_pc<=pc, if_id_pc_next<=pc+PC_STEP, if_id_valid<=1
  - pc<=pc+PC_STEP
- Stall (redirect=0, stall=1): pc and all if_id_* hold their values, including if_id_valid. Stall overrides fetch_en.
- Fetch disabled (redirect=0, stall=0, fetch_en=0): pc holds. if_id_valid<=0 and if_id_instr<=16'h0000; if_id_pc and if_id_pc_next hold.
- Redirect (redirect=1, regardless of stall/fetch_en):
  - pc<=redirect_target
  - if_id_valid<=0 and if_id_instr<=16'h0000 (wrong-path squash); if_id_pc and if_id_pc_next hold
  - The first target instruction is latched on the next eligible edge.
- Arithmetic: all PC math is 16-bit modulo, so 16'hFFFF + 1 = 16'h0000 with no error flag. if_id_pc_next wraps the same way.
- fetch_count: increments by 1 on each edge where if_id_valid is loaded with 1 (normal case only). It saturates at 16'hFFFF and does not increment during stall hold.
- Reset asserted mid-operation (including during a stall or redirect) overrides everything asynchronously. First fetch after reset_n rises is from RESET_PC.
- There is no combinational path from stall or redirect to imem_addr; the PC changes only at clock edges.

Test Plan:
1. Memory preloaded 0:2009, 1:200A, 2:012A, 3:012B; reset then release, fetch_en=1 for 4 edges -> if_id_instr sequence 2009, 200A, 012A, 012B with if_id_pc 0,1,2,3, if_id_pc_next 1,2,3,4, valid=1 each edge, fetch_count=4.
2. At pc=2, assert stall for 3 edges -> if_id_instr stays 200A, pc stays 2, fetch_count unchanged. Deassert stall -> next edge latches 012A.
3. At pc=3, redirect=1 with redirect_target=16'h0001 and stall=1 together -> next edge pc=1, if_id_valid=0, if_id_instr=0000. Following edge latches 200A with if_id_pc=1.
4. fetch_en=0 for 2 edges at pc=1 -> if_id_valid=0, pc=1 held, count frozen. Re-enable -> 200A latched.
5. Redirect to 16'hFFFF, then one normal edge -> if_id_pc=FFFF, if_id_pc_next=0000, pc=0000.
6. Pull reset_n low between clock edges during a stall -> all outputs at reset values immediately, before the next edge. After release, first latched if_id_pc=RESET_PC.
